// File: rtl/gcd_pkg.sv
// Shared types and the round-robin pick used by the GCD scheduler.
package gcd_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_FLUSH
    } gcd_sched_state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // Requests above NReq are zero-padded, so wrapping at 16 is equivalent to wrapping at NReq.
    function automatic rr_pick_t rr_pick(input logic [15:0] req, input logic [3:0] ptr);
        rr_pick_t   r;
        logic [3:0] idx;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr + 4'(i);
            if (!r.found && req[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gcd_sched_rr_arbiter.sv
// Round-robin pick over NReq requests; combinational grant, pointer advances past the winner on adv.
module rr_arbiter
    import gcd_pkg::*;
#(
    parameter int NReq = 4,
    localparam int IdW = $clog2(NReq)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            adv,
    input  logic [NReq-1:0] req_i,
    output logic [NReq-1:0] gnt_o,
    output logic [IdW-1:0]  gnt_id_o,
    output logic            found_o
);

    localparam logic [IdW-1:0] LastId = IdW'(NReq - 1);

    logic [IdW-1:0] ptr_q;
    logic [IdW-1:0] ptr_d;
    rr_pick_t       pick;

    always_comb begin
        pick     = rr_pick(16'(req_i), 4'(ptr_q));
        found_o  = pick.found;
        gnt_id_o = pick.idx[IdW-1:0];
        gnt_o    = pick.found ? (NReq'(1) << gnt_id_o) : '0;
        ptr_d    = (gnt_id_o == LastId) ? '0 : gnt_id_o + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (adv) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gcd_sched.sv
// Shares one GCD core among NReq requesters; response at grant+2+k cycles, or grant+2+MaxCycles on abort.
// Requests wait on req_valid until granted; the response bus has no backpressure.
module gcd_sched
    import gcd_pkg::*;
#(
    parameter int NBits     = 8,
    parameter int NReq      = 4,
    parameter int MaxCycles = 64,
    localparam int IdW      = $clog2(NReq)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NReq-1:0]       req_valid,
    input  logic [NReq*NBits-1:0] req_x,
    input  logic [NReq*NBits-1:0] req_y,
    output logic [NReq-1:0]       req_ready,
    output logic                  resp_valid,
    output logic [IdW-1:0]        resp_id,
    output logic [NBits-1:0]      resp_data,
    output logic                  resp_err,
    output logic [NBits-1:0]      core_xi,
    output logic [NBits-1:0]      core_yi,
    output logic                  core_start,
    output logic                  core_rst,
    input  logic [NBits-1:0]      core_xo,
    input  logic                  core_rdy
);

    localparam int CntW = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MaxCycles - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxCycles);

    gcd_sched_state_t state_q, state_d;
    logic [NBits-1:0] x_q, x_d, y_q, y_d, data_q, data_d;
    logic [IdW-1:0]   id_q, id_d;
    logic             err_q, err_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [NReq-1:0]  gnt;
    logic [IdW-1:0]   gnt_id;
    logic             found;
    logic             grant;

    assign grant = (state_q == S_IDLE) && found;

    rr_arbiter #(.NReq(NReq)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .adv      (grant),
        .req_i    (req_valid),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id),
        .found_o  (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN: begin
                if (core_rdy)              state_d = S_DONE;
                else if (cnt_q == CntLast) state_d = S_FLUSH;
            end
            S_DONE:  state_d = S_IDLE;
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are masked during reset so a reset landing in IDLE/DONE/FLUSH emits nothing.
    always_comb begin
        req_ready  = '0;
        resp_valid = 1'b0;
        core_start = 1'b0;
        case (state_q)
            S_IDLE:  req_ready  = rst ? '0 : gnt;
            S_RUN:   core_start = 1'b1;
            S_DONE:  resp_valid = !rst;
            S_FLUSH: resp_valid = !rst;
            default: ;
        endcase
        core_rst = rst || (state_q == S_FLUSH);
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        id_d   = id_q;
        data_d = data_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    for (int i = 0; i < NReq; i++) begin
                        if (gnt[i]) begin
                            x_d = req_x[i*NBits +: NBits];
                            y_d = req_y[i*NBits +: NBits];
                        end
                    end
                    id_d = gnt_id;
                end
            end
            S_LOAD: cnt_d = '0;
            S_RUN: begin
                if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
                if (core_rdy) begin
                    data_d = core_xo;
                    err_d  = 1'b0;
                end else if (cnt_q == CntLast) begin
                    data_d = '0;
                    err_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            id_q   <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            id_q   <= id_d;
            data_q <= data_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign core_xi   = x_q;
    assign core_yi   = y_q;
    assign resp_id   = id_q;
    assign resp_data = data_q;
    assign resp_err  = err_q;

endmodule
